// File: rtl/nibble_deserializer.sv
// Serial-to-parallel word assembler with valid/ready output, internal back-pressure
// and sync-marker realignment of word boundaries.
module nibble_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_sync,
  output logic             sin_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             sync_err,
  input  logic             err_clr
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             sync_err_q, sync_err_d;

  logic             accept;
  logic             drain;
  logic             err_set;
  logic [WIDTH-1:0] word;

  // Bit index k lands at WIDTH-1-k when the stream is MSB first.
  function automatic logic [CW-1:0] pos(input logic [CW-1:0] k);
    return MSB_FIRST ? (LAST - k) : k;
  endfunction

  assign sin_ready = (state_q == COLLECT);
  assign accept    = sin_valid && sin_ready;
  assign drain     = dout_valid_q && dout_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    err_set      = 1'b0;
    word         = sh_q;
    word[pos(cnt_q)] = sin;

    if (drain) begin
      dout_valid_d = 1'b0;
    end

    if (state_q == FULL) begin
      if (drain) begin
        dout_d       = sh_q;
        dout_valid_d = 1'b1;
        state_d      = COLLECT;
      end
    end else if (accept) begin
      if (sin_sync) begin
        sh_d           = '0;
        sh_d[pos('0)]  = sin;
        cnt_d          = CW'(1);
        err_set        = (cnt_q != '0);
      end else if (cnt_q != LAST) begin
        sh_d  = word;
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
        // Deliver straight to the output register if it is free this cycle,
        // otherwise park the word in sh and stall the serial side.
        if (!dout_valid_q || drain) begin
          dout_d       = word;
          dout_valid_d = 1'b1;
        end else begin
          sh_d    = word;
          state_d = FULL;
        end
      end
    end

    sync_err_d = err_set || (sync_err_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      cnt_q        <= '0;
      sh_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sync_err   = sync_err_q;

endmodule

// File: doc/nibble_deserializer.md
Name: nibble_deserializer

Overview:
Serial-to-parallel front end that assembles a 1-bit stream into WIDTH-bit words and presents each word on a valid/ready output port.
It sits directly upstream of the team's 4-bit data register and feeds that register's d input.
Internal back-pressure stalls the serial source when a finished word cannot be delivered.
An optional per-bit sync marker re-aligns word boundaries.

Parameters:
WIDTH, 4, word width in bits; legal range ≥2.
MSB_FIRST, 1, 1 = first serial bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
sin  input  1  serial data bit.
sin_valid  input  1  sin is valid this cycle.
sin_sync  input  1  qualified by sin_valid; marks the current bit as bit 0 of a new word.
sin_ready  output  1  block accepts a bit this cycle.
dout  output  WIDTH  assembled word.
dout_valid  output  1  dout holds an undelivered word.
dout_ready  input  1  consumer accepts dout this cycle.
sync_err  output  1  sticky flag: a partial word was discarded by sin_sync.
err_clr  input  1  clears sync_err.

Behaviour:
- Internal state: shift register sh[WIDTH-1:0]; bit counter cnt (0..WIDTH-1); FSM {COLLECT, FULL}; output register dout/dout_valid.
- Reset (rst=1 at an edge):
  - state=COLLECT, cnt=0, sh=0, dout=0, dout_valid=0, sync_err=0.
  - rst overrides all other inputs.
  - Reset mid-word or in FULL discards all held data.
- Handshakes:
  - sin_ready = (state==COLLECT); combinational from state only.
  - A bit is accepted when sin_valid && sin_ready.
  - A word is drained when dout_valid && dout_ready.
- Bit placement: accepted bit k (k = cnt) goes to position WIDTH-1-k if MSB_FIRST, else position k.
- COLLECT, accepted bit with cnt<WIDTH-1 and sin_sync=0: write the bit; cnt <= cnt+1.
- Accepted bit with sin_sync=1:
  - sh is cleared except the new bit, written at position for k=0; cnt <= 1.
  - If cnt was ≠0, the partial word is discarded and sync_err <= 1.
  - WIDTH≥2, so a sync bit never completes a word.
- COLLECT, accepted bit with cnt==WIDTH-1 and sin_sync=0: the assembled word W = sh with the final bit inserted.
  - If !dout_valid or a drain occurs this cycle: dout <= W, dout_valid <= 1, cnt <= 0, stay in COLLECT.
  - Otherwise: sh <= W, state <= FULL, cnt <= 0.
- FULL: sin_ready=0. On a drain: dout <= sh, dout_valid stays 1, state <= COLLECT. Without a drain, hold.
- A drain with no new word loaded that cycle: dout_valid <= 0.
- Latency: last bit accepted at edge N → dout/dout_valid updated after edge N.
- Throughput: one bit per cycle sustained whenever dout_ready is held high. No bubbles at word boundaries.
- dout is stable while dout_valid=1 and dout_ready=0.
- sync_err:
  - err_clr=1 clears it.
  - A set event in the same cycle as err_clr wins: sync_err=1.
- Bits presented while sin_ready=0 are ignored; the source must hold them.
- sin and sin_sync are don't-care when sin_valid=0.

Test Plan:
- Reset check: assert rst for 2 cycles mid-word → dout=0, dout_valid=0, sin_ready=1, sync_err=0; the next 4 bits form a fresh word.
- Basic MSB_FIRST=1: bits 1,0,1,1 on consecutive cycles, dout_ready=1 → dout=4'b1011, dout_valid=1 for exactly one cycle after the 4th bit.
- LSB_FIRST (MSB_FIRST=0): bits 1,0,1,1 → dout=4'b1101.
- Back-pressure: dout_ready=0; send words 4'hA then 4'h5 → dout holds 4'hA, FSM enters FULL, sin_ready=0. Raise dout_ready → 4'h5 appears the next cycle, then sin_ready=1.
- Sync re-align: send bits 1,1, then sync bit 0 followed by 1,1,0 → sync_err=1, dout=4'b0110. Pulse err_clr → sync_err=0.
- Streaming: 16 back-to-back bits with dout_ready=1 → 4 words, one every 4 cycles, sin_ready never drops, values match the input.
